// File: rtl/usb_dev_if.sv
// Host-side bus between the decoded-packet host model and the USB device controller.
// The master drives decoded tokens and data bytes; the slave returns responses and a configured flag.
interface usb_dev_if;
  logic        host_pkt_valid;
  logic [3:0]  host_pid;
  logic [6:0]  host_addr;
  logic [3:0]  host_ep;
  logic [7:0]  host_data;
  logic        host_data_valid;
  logic [15:0] host_data_len;
  logic        host_crc_err;
  logic        host_tx_valid;
  logic [3:0]  host_tx_pid;
  logic [7:0]  host_tx_data;
  logic [15:0] host_tx_len;
  logic        configured;

  modport master (
    output host_pkt_valid, host_pid, host_addr, host_ep, host_data,
           host_data_valid, host_data_len, host_crc_err,
    input  host_tx_valid, host_tx_pid, host_tx_data, host_tx_len, configured
  );

  modport slave (
    input  host_pkt_valid, host_pid, host_addr, host_ep, host_data,
           host_data_valid, host_data_len, host_crc_err,
    output host_tx_valid, host_tx_pid, host_tx_data, host_tx_len, configured
  );
endinterface

// File: rtl/usb_dev_ctrl.sv
// Transaction-level USB full-speed device controller: EP0 SETUP decode and an EP1 bulk FIFO.
// Accepts decoded tokens/bytes and emits registered handshake or data responses.
module usb_dev_ctrl #(
  parameter int unsigned EP1_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  usb_dev_if.slave   bus,
  output logic [6:0] dbg_addr_reg,
  output logic [3:0] dbg_ep1_fifo_level
);
  localparam int unsigned PTR_W = $clog2(EP1_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [7:0] REQ_SET_ADDRESS = 8'h05;
  localparam logic [7:0] REQ_SET_CONFIG  = 8'h09;

  typedef enum logic [1:0] {IDLE, RX_DATA, RESP, TX_DATA} state_t;

  state_t           state;
  logic [6:0]       addr_reg;
  logic             toggle;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] tx_left;
  logic [15:0]      count;
  logic [3:0]       rx_idx;
  logic [3:0]       tok_pid;
  logic             tok_ep;
  logic [15:0]      tok_len;
  logic             bad;
  logic             ep1_ok;
  logic [7:0]       breq;
  logic [7:0]       wval;
  logic             pend_addr;
  logic [6:0]       new_addr;
  logic [7:0]       mem [EP1_DEPTH];

  logic             tok_c;
  logic             byte_c;
  logic [15:0]      free_c;
  logic             wr_en_c;
  logic [PTR_W-1:0] wr_idx_c;
  logic [3:0]       resp_pid_c;

  assign dbg_addr_reg       = addr_reg;
  assign dbg_ep1_fifo_level = 4'(level);

  // Token qualification: supported PID, our address, endpoint 0 or 1.
  assign tok_c = bus.host_pkt_valid && !bus.host_data_valid &&
                 (bus.host_pid == PID_SETUP || bus.host_pid == PID_OUT || bus.host_pid == PID_IN) &&
                 (bus.host_addr == addr_reg) && (bus.host_ep <= 4'd1);
  assign byte_c   = bus.host_pkt_valid && bus.host_data_valid && (state == RX_DATA);
  assign free_c   = 16'(EP1_DEPTH) - 16'(level);
  assign wr_en_c  = byte_c && (tok_pid == PID_OUT) && tok_ep && ep1_ok;
  assign wr_idx_c = wr_ptr + PTR_W'(rx_idx);

  // Response decision for a completed non-burst transaction.
  always_comb begin
    resp_pid_c = PID_STALL;
    case (tok_pid)
      PID_IN:  resp_pid_c = tok_ep ? PID_NAK : PID_DATA1;
      PID_OUT: resp_pid_c = (!tok_ep || ep1_ok) ? PID_ACK : PID_NAK;
      default: resp_pid_c = (!tok_ep && tok_len == 16'd8 &&
                             (breq == REQ_SET_ADDRESS || breq == REQ_SET_CONFIG)) ? PID_ACK : PID_STALL;
    endcase
  end

  // OUT bytes land speculatively past wr_ptr; they only become visible when RESP commits.
  always_ff @(posedge clk) begin
    if (wr_en_c) mem[wr_idx_c] <= bus.host_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      bus.host_tx_valid <= 1'b0;
      bus.host_tx_pid   <= 4'h0;
      bus.host_tx_data  <= 8'h00;
      bus.host_tx_len   <= 16'h0000;
      bus.configured    <= 1'b0;
      addr_reg          <= 7'h00;
      toggle            <= 1'b0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      level             <= '0;
      tx_left           <= '0;
      count             <= 16'h0000;
      rx_idx            <= 4'h0;
      tok_pid           <= 4'h0;
      tok_ep            <= 1'b0;
      tok_len           <= 16'h0000;
      bad               <= 1'b0;
      ep1_ok            <= 1'b0;
      breq              <= 8'h00;
      wval              <= 8'h00;
      pend_addr         <= 1'b0;
      new_addr          <= 7'h00;
    end else begin
      bus.host_tx_valid <= 1'b0;
      bus.host_tx_pid   <= 4'h0;
      bus.host_tx_data  <= 8'h00;
      bus.host_tx_len   <= 16'h0000;

      // New address takes effect one cycle after its ACK pulse.
      if (pend_addr) begin
        addr_reg  <= new_addr;
        pend_addr <= 1'b0;
      end

      if ((state == IDLE || state == RX_DATA) && tok_c) begin
        tok_pid <= bus.host_pid;
        tok_ep  <= bus.host_ep[0];
        tok_len <= bus.host_data_len;
        count   <= bus.host_data_len;
        rx_idx  <= 4'h0;
        bad     <= bus.host_crc_err;
        ep1_ok  <= (bus.host_data_len <= free_c);
        if (bus.host_pid == PID_IN) begin
          if (bus.host_crc_err) begin
            state <= IDLE;
          end else if (bus.host_ep == 4'd0 || level == '0) begin
            state <= RESP;
          end else begin
            state             <= TX_DATA;
            bus.host_tx_valid <= 1'b1;
            bus.host_tx_pid   <= toggle ? PID_DATA1 : PID_DATA0;
            bus.host_tx_len   <= 16'(level);
            bus.host_tx_data  <= mem[rd_ptr];
            rd_ptr            <= rd_ptr + PTR_W'(1);
            level             <= level - LVL_W'(1);
            tx_left           <= level - LVL_W'(1);
          end
        end else if (bus.host_data_len == 16'h0000) begin
          state <= bus.host_crc_err ? IDLE : RESP;
        end else begin
          state <= RX_DATA;
        end
      end else begin
        case (state)
          RX_DATA: begin
            if (byte_c) begin
              if (bus.host_crc_err) bad <= 1'b1;
              if (rx_idx == 4'd1) breq <= bus.host_data;
              if (rx_idx == 4'd2) wval <= bus.host_data;
              rx_idx <= rx_idx + 4'd1;
              count  <= count - 16'd1;
              if (count == 16'd1) state <= (bad || bus.host_crc_err) ? IDLE : RESP;
            end
          end
          RESP: begin
            bus.host_tx_valid <= 1'b1;
            bus.host_tx_pid   <= resp_pid_c;
            state             <= IDLE;
            if (tok_pid == PID_OUT && tok_ep && ep1_ok) begin
              wr_ptr <= wr_ptr + PTR_W'(tok_len);
              level  <= level + LVL_W'(tok_len);
            end
            if (tok_pid == PID_SETUP && resp_pid_c == PID_ACK) begin
              if (breq == REQ_SET_ADDRESS) begin
                pend_addr <= 1'b1;
                new_addr  <= wval[6:0];
              end else begin
                bus.configured <= (wval != 8'h00);
              end
            end
          end
          TX_DATA: begin
            if (tx_left == '0) begin
              toggle <= ~toggle;
              state  <= IDLE;
            end else begin
              bus.host_tx_valid <= 1'b1;
              bus.host_tx_pid   <= toggle ? PID_DATA1 : PID_DATA0;
              bus.host_tx_len   <= bus.host_tx_len;
              bus.host_tx_data  <= mem[rd_ptr];
              rd_ptr            <= rd_ptr + PTR_W'(1);
              level             <= level - LVL_W'(1);
              tx_left           <= tx_left - LVL_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_usb_dev_ctrl.sv
// Self-checking bench for usb_dev_ctrl: transaction table plus hand-written abort/reset sequences.
// Expected response beats (pid, data, len, arrival cycle) are queued at drive time and popped as they appear.
module tb_usb_dev_ctrl;
  localparam logic [3:0] P_OUT = 4'h1, P_IN = 4'h9, P_SETUP = 4'hD, P_D0 = 4'h3;
  localparam logic [3:0] P_D1 = 4'hB, P_ACK = 4'h2, P_NAK = 4'hA, P_STALL = 4'hE;

  logic       clk;
  logic       rst_n;
  logic [6:0] dbg_addr_reg;
  logic [3:0] dbg_ep1_fifo_level;

  usb_dev_if bus();

  usb_dev_ctrl #(.EP1_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .dbg_addr_reg(dbg_addr_reg), .dbg_ep1_fifo_level(dbg_ep1_fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  pid;
    logic [7:0]  data;
    logic [15:0] len;
    int          due;
  } exp_t;

  typedef struct {
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  ep;
    logic [15:0] len;
    logic [63:0] bytes;
    int          crc_at;   // -1 none, 8 on token, else byte index
    bit          resp;
    logic [3:0]  exp_pid;
    logic [6:0]  exp_addr;
    logic [3:0]  exp_lvl;
  } vec_t;

  exp_t       exq[$];
  logic [7:0] mq[$];
  vec_t       vt[$];

  function automatic vec_t mk(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep,
                              input logic [15:0] len, input logic [63:0] bytes, input int crc_at,
                              input bit resp, input logic [3:0] exp_pid,
                              input logic [6:0] exp_addr, input logic [3:0] exp_lvl);
    vec_t v;
    v.pid = pid; v.addr = addr; v.ep = ep; v.len = len; v.bytes = bytes; v.crc_at = crc_at;
    v.resp = resp; v.exp_pid = exp_pid; v.exp_addr = exp_addr; v.exp_lvl = exp_lvl;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] pid, input logic [7:0] data, input logic [15:0] len, input int due);
    exp_t e;
    e.pid = pid; e.data = data; e.len = len; e.due = due;
    exq.push_back(e);
  endtask

  task automatic sample_tx();
    exp_t e;
    if (bus.host_tx_valid !== 1'b0) begin
      tests++;
      if (exq.size() == 0) begin
        fails++;
        $display("FAIL unexpected_tx got pid=%h data=%h len=%0d cyc=%0d",
                 bus.host_tx_pid, bus.host_tx_data, bus.host_tx_len, cyc);
      end else begin
        e = exq.pop_front();
        if (bus.host_tx_pid !== e.pid || bus.host_tx_data !== e.data ||
            bus.host_tx_len !== e.len || cyc != e.due) begin
          fails++;
          $display("FAIL tx_beat got pid=%h data=%h len=%0d cyc=%0d exp pid=%h data=%h len=%0d cyc=%0d",
                   bus.host_tx_pid, bus.host_tx_data, bus.host_tx_len, cyc,
                   e.pid, e.data, e.len, e.due);
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample_tx();
  endtask

  task automatic drive_tok(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep,
                           input logic [15:0] len, input logic crc);
    tick();
    bus.host_pkt_valid = 1'b1; bus.host_data_valid = 1'b0;
    bus.host_pid = pid; bus.host_addr = addr; bus.host_ep = ep;
    bus.host_data_len = len; bus.host_crc_err = crc; bus.host_data = 8'h00;
  endtask

  task automatic drive_byte(input logic [7:0] b, input logic crc);
    tick();
    bus.host_pkt_valid = 1'b1; bus.host_data_valid = 1'b1;
    bus.host_pid = P_D0; bus.host_data = b; bus.host_crc_err = crc;
  endtask

  task automatic drive_idle();
    tick();
    bus.host_pkt_valid = 1'b0; bus.host_data_valid = 1'b0; bus.host_crc_err = 1'b0;
  endtask

  // Bounded wait for all queued beats; a leftover entry counts as a missing response.
  task automatic drain(input string name);
    for (int i = 0; i < 16; i++) drive_idle();
    tests++;
    if (exq.size() != 0) begin
      fails++;
      $display("FAIL %s_missing_tx got=%0d pending exp=0", name, exq.size());
      exq.delete();
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         t;
    int         n;
    logic [7:0] b;
    drive_tok(v.pid, v.addr, v.ep, v.len, v.crc_at == 8);
    if (v.pid != P_IN) begin
      for (int i = 0; i < int'(v.len); i++) begin
        b = v.bytes[8*i +: 8];
        drive_byte(b, v.crc_at == i);
      end
    end
    t = cyc;
    if (v.resp) begin
      if (v.pid == P_IN && v.ep == 4'd1 && v.exp_pid != P_NAK) begin
        n = mq.size();
        for (int i = 0; i < n; i++) push_exp(v.exp_pid, mq.pop_front(), 16'(n), t + 1 + i);
      end else begin
        push_exp(v.exp_pid, 8'h00, 16'h0000, t + 2);
        if (v.pid == P_OUT && v.ep == 4'd1 && v.exp_pid == P_ACK)
          for (int i = 0; i < int'(v.len); i++) mq.push_back(v.bytes[8*i +: 8]);
      end
    end
    drain($sformatf("v%0d", idx));
    check($sformatf("v%0d_addr", idx), 64'(dbg_addr_reg), 64'(v.exp_addr));
    check($sformatf("v%0d_level", idx), 64'(dbg_ep1_fifo_level), 64'(v.exp_lvl));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.host_pkt_valid = 1'b0; bus.host_data_valid = 1'b0; bus.host_pid = 4'h0;
    bus.host_addr = 7'h00; bus.host_ep = 4'h0; bus.host_data = 8'h00;
    bus.host_data_len = 16'h0000; bus.host_crc_err = 1'b0;

    //           pid      addr   ep  len  bytes (byte0 in LSB)      crc resp exp_pid  addr   lvl
    vt.push_back(mk(P_SETUP, 7'h00, 0, 8, 64'h0000_0000_0000_FF00, -1, 1, P_STALL, 7'h00, 0));
    vt.push_back(mk(P_SETUP, 7'h00, 0, 8, 64'h0000_0000_002A_0500, -1, 1, P_ACK,   7'h2A, 0));
    vt.push_back(mk(P_IN,    7'h00, 0, 0, 64'h0,                   -1, 0, P_NAK,   7'h2A, 0));
    vt.push_back(mk(P_IN,    7'h2A, 0, 0, 64'h0,                   -1, 1, P_D1,    7'h2A, 0));
    vt.push_back(mk(P_OUT,   7'h2A, 1, 3, 64'h0000_0000_0033_2211, -1, 1, P_ACK,   7'h2A, 3));
    vt.push_back(mk(P_IN,    7'h2A, 1, 0, 64'h0,                   -1, 1, P_D0,    7'h2A, 0));
    vt.push_back(mk(P_IN,    7'h2A, 1, 0, 64'h0,                   -1, 1, P_NAK,   7'h2A, 0));
    vt.push_back(mk(P_OUT,   7'h2A, 1, 6, 64'h0000_0605_0403_0201, -1, 1, P_ACK,   7'h2A, 6));
    vt.push_back(mk(P_OUT,   7'h2A, 1, 4, 64'h0000_0000_7766_5544, -1, 1, P_NAK,   7'h2A, 6));
    vt.push_back(mk(P_IN,    7'h2A, 1, 0, 64'h0,                   -1, 1, P_D1,    7'h2A, 0));
    vt.push_back(mk(P_IN,    7'h2A, 2, 0, 64'h0,                   -1, 0, P_NAK,   7'h2A, 0));
    vt.push_back(mk(P_SETUP, 7'h2A, 0, 8, 64'h0000_0000_0033_0500,  3, 0, P_NAK,   7'h2A, 0));
    vt.push_back(mk(P_SETUP, 7'h2A, 0, 8, 64'h0000_0000_0001_0900, -1, 1, P_ACK,   7'h2A, 0));
    vt.push_back(mk(P_SETUP, 7'h2A, 0, 4, 64'h0000_0000_0011_0500, -1, 1, P_STALL, 7'h2A, 0));
    vt.push_back(mk(P_OUT,   7'h2A, 0, 2, 64'h0000_0000_0000_BBAA, -1, 1, P_ACK,   7'h2A, 0));
    vt.push_back(mk(P_OUT,   7'h2A, 1, 2, 64'h0000_0000_0000_CCDD,  8, 0, P_NAK,   7'h2A, 0));
    vt.push_back(mk(P_OUT,   7'h2A, 1, 8, 64'hF8F7_F6F5_F4F3_F2F1, -1, 1, P_ACK,   7'h2A, 8));
    vt.push_back(mk(P_OUT,   7'h2A, 1, 1, 64'h0000_0000_0000_0099, -1, 1, P_NAK,   7'h2A, 8));
    vt.push_back(mk(P_IN,    7'h2A, 1, 0, 64'h0,                   -1, 1, P_D0,    7'h2A, 0));

    @(negedge clk);
    @(negedge clk);
    check("reset_outputs",
          {24'h0, bus.host_tx_valid, bus.host_tx_pid, bus.host_tx_data, bus.host_tx_len,
           dbg_addr_reg, dbg_ep1_fifo_level}, 64'h0);
    rst_n = 1'b1;

    foreach (vt[i]) run_vec(vt[i], i);
    check("configured_after_set_config", 64'(bus.configured), 64'h1);

    // Token arriving mid-OUT aborts it: EP0 IN answers, partial EP1 bytes never commit.
    drive_tok(P_OUT, 7'h2A, 4'd1, 16'd3, 1'b0);
    drive_byte(8'hAA, 1'b0);
    drive_tok(P_IN, 7'h2A, 4'd0, 16'd0, 1'b0);
    push_exp(P_D1, 8'h00, 16'h0000, cyc + 2);
    drain("abort");
    check("abort_level", 64'(dbg_ep1_fifo_level), 64'h0);
    drive_tok(P_IN, 7'h2A, 4'd1, 16'd0, 1'b0);
    push_exp(P_NAK, 8'h00, 16'h0000, cyc + 2);
    drain("abort_in_after");

    // Asynchronous reset in the middle of a SETUP data stage.
    drive_tok(P_SETUP, 7'h2A, 4'd0, 16'd8, 1'b0);
    drive_byte(8'h00, 1'b0);
    drive_byte(8'h05, 1'b0);
    drive_byte(8'h11, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrx_reset_outputs",
          {24'h0, bus.host_tx_valid, bus.host_tx_pid, bus.host_tx_data, bus.host_tx_len,
           dbg_addr_reg, dbg_ep1_fifo_level}, 64'h0);
    drive_idle();
    rst_n = 1'b1;
    mq.delete();
    run_vec(mk(P_SETUP, 7'h00, 0, 8, 64'h0000_0000_0000_FF00, -1, 1, P_STALL, 7'h00, 0), 100);
    run_vec(mk(P_SETUP, 7'h00, 0, 8, 64'h0000_0000_0015_0500, -1, 1, P_ACK,   7'h15, 0), 101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/usb_dev_ctrl.md
Name: usb_dev_ctrl

Overview:
- Transaction-level USB full-speed device controller; the PHY/SIE layers are abstracted away.
- Accepts already-decoded host packets: tokens and data bytes with length and CRC status.
- Runs EP0 control SETUP decoding and an 8-byte EP1 bulk FIFO.
- Emits handshake/data responses toward the host. Sits between the host-side bus model and device application logic.

Parameters:
- EP1_DEPTH, 8, EP1 FIFO depth in bytes; level is 4 bits wide.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- host_pkt_valid  in  1  qualifies a token (data_valid=0) or a data byte (data_valid=1).
- host_pid  in  4  USB PID: OUT=1, IN=9, SETUP=D, DATA0=3, DATA1=B, ACK=2, NAK=A, STALL=E.
- host_addr  in  7  token device address.
- host_ep  in  4  token endpoint number.
- host_data  in  8  payload byte.
- host_data_valid  in  1  payload byte strobe.
- host_data_len  in  16  payload byte count of the current transaction, sampled with the token.
- host_crc_err  in  1  CRC failure flag for the current token or byte.
- host_tx_valid  out  1  response strobe.
- host_tx_pid  out  4  response PID.
- host_tx_data  out  8  response data byte.
- host_tx_len  out  16  response payload length.
- dbg_addr_reg  out  7  current device address.
- dbg_ep1_fifo_level  out  4  EP1 FIFO occupancy, 0..8.

Behaviour:
- Reset values (asynchronous, all registered):
  - host_tx_valid=0, host_tx_pid=0, host_tx_data=0, host_tx_len=0.
  - addr_reg=0, EP1 FIFO empty (level 0), data toggle=DATA0, state IDLE.
- Token accept: host_pkt_valid=1 and host_data_valid=0, PID in {SETUP, OUT, IN}, and host_addr==addr_reg. Otherwise the token is ignored.
- Endpoint range: host_ep>1 ignored; no response.
- Data byte accept: host_pkt_valid=1 and host_data_valid=1, only in state RX_DATA. The host_pid value during bytes is don't-care.
- States: IDLE, RX_DATA, RESP, TX_DATA.
- IDLE:
  - SETUP/OUT -> RX_DATA with count=host_data_len. If host_data_len==0, go directly to RESP.
  - IN -> RESP (EP0) or TX_DATA/RESP (EP1).
- RX_DATA:
  - Each accepted byte is stored and count decremented.
  - On the final byte -> RESP.
  - A new valid token arriving in RX_DATA aborts the current transaction and restarts from that token.
- CRC: host_crc_err=1 on the token or any byte marks the transaction bad. Bytes are still consumed, no response is issued and no state is changed; return to IDLE.
- RESP: host_tx_valid=1 for exactly one cycle, on the clock edge after the edge sampling the final byte (or the token, if there is no payload). host_tx_len=0, host_tx_data=0. Then IDLE.
- EP0 SETUP (8 bytes: bmRequestType, bRequest, wValue L/H, wIndex L/H, wLength L/H):
  - bRequest 0x05 SET_ADDRESS: ACK; addr_reg<=wValue[6:0], updated the cycle after the ACK pulse.
  - bRequest 0x09 SET_CONFIGURATION: ACK; internal configured flag <= (wValue[7:0]!=0).
  - Any other bRequest, or a SETUP length !=8: STALL.
- EP0 IN: zero-length DATA1 (status stage).
- EP0 OUT: ACK.
- EP1 OUT:
  - If host_data_len <= free space at the token: bytes are pushed and the response is ACK.
  - Otherwise all bytes are dropped and the response is NAK.
- EP1 IN:
  - FIFO empty: NAK.
  - Otherwise TX_DATA: host_tx_valid=1 for N=level consecutive cycles, starting the cycle after the token.
  - During TX_DATA: host_tx_pid=current toggle (DATA0/DATA1), host_tx_len=N, host_tx_data=FIFO head, popped each cycle.
  - The toggle flips at the end of the burst.
- Inputs arriving in RESP/TX_DATA are ignored.
- dbg_ep1_fifo_level updates the cycle after each push/pop. The FIFO uses wrap-around pointers and never over- or under-flows.

Test Plan:
- Reset, SETUP addr0 ep0 len8 with bytes 00 FF 00 00 00 00 00 00 -> single host_tx_valid pulse with host_tx_pid=E (STALL), len 0.
- SETUP with bytes 00 05 2A 00 00 00 00 00 -> ACK (2); dbg_addr_reg becomes 0x2A. A following token to addr 0 is ignored; tokens to addr 0x2A are answered.
- OUT ep1 len3, bytes 11 22 33 -> ACK, level=3. IN ep1 -> DATA0 (3) bytes 11,22,33 over 3 cycles with len 3, level 0. Second IN -> NAK (A).
- OUT ep1 len6 then OUT ep1 len4 -> first ACK, level 6; second NAK, level stays 6.
- SETUP SET_ADDRESS with host_crc_err=1 on byte 3 -> no host_tx_valid; dbg_addr_reg unchanged.
- Assert rst_n=0 mid-RX_DATA -> all outputs are 0 immediately. Resend a full SETUP -> normal response.
